// File: rtl/intra_mcm_tap_sequencer.sv
// rtl/intra_mcm_tap_sequencer.sv - 4-tap intra interpolator time-multiplexed over one shared MCM
module intra_mcm_tap_sequencer #(
    parameter int SHIFT = 4,
    parameter int ACC_W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_samples,
    input  logic [19:0]  in_codes,
    output logic [7:0]   mcm_x,
    input  logic [351:0] mcm_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         busy,
    output logic         code_err
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (SHIFT - 1));

    state_t                   state_q, state_d;
    logic [1:0]               tap_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [31:0]              samples_q;
    logic [19:0]              codes_q;
    logic [7:0]               out_data_q;
    logic                     code_err_q;

    logic [7:0]               cur_sample;
    logic [4:0]               cur_code;
    logic                     code_ok;
    logic [15:0]              product;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [7:0]               clipped;

    always_comb begin
        cur_sample = samples_q[7:0];
        cur_code   = codes_q[4:0];
        case (tap_q)
            2'd0: begin cur_sample = samples_q[7:0];   cur_code = codes_q[4:0];   end
            2'd1: begin cur_sample = samples_q[15:8];  cur_code = codes_q[9:5];   end
            2'd2: begin cur_sample = samples_q[23:16]; cur_code = codes_q[14:10]; end
            default: begin cur_sample = samples_q[31:24]; cur_code = codes_q[19:15]; end
        endcase
    end

    // Codes 22..31 have no MCM output behind them and contribute zero.
    always_comb begin
        product = 16'd0;
        code_ok = 1'b0;
        for (int k = 0; k < 22; k++) begin
            if (cur_code == 5'(k)) begin
                product = mcm_y[k*16 +: 16];
                code_ok = 1'b1;
            end
        end
    end

    always_comb begin
        sum     = acc_q + {{(ACC_W-16){product[15]}}, product};
        shifted = (sum + RND) >>> SHIFT;
        if (shifted[ACC_W-1])
            clipped = 8'd0;
        else if (|shifted[ACC_W-2:8])
            clipped = 8'd255;
        else
            clipped = shifted[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)     state_d = S_MAC;
            S_MAC:   if (tap_q == 2'd3) state_d = S_DONE;
            S_DONE:  if (out_ready)    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        mcm_x     = (state_q == S_MAC) ? cur_sample : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q      <= 2'd0;
            acc_q      <= '0;
            samples_q  <= '0;
            codes_q    <= '0;
            out_data_q <= 8'd0;
            code_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        samples_q  <= in_samples;
                        codes_q    <= in_codes;
                        acc_q      <= '0;
                        tap_q      <= 2'd0;
                        code_err_q <= 1'b0;
                    end
                end
                S_MAC: begin
                    acc_q <= sum;
                    tap_q <= tap_q + 2'd1;
                    if (!code_ok)
                        code_err_q <= 1'b1;
                    if (tap_q == 2'd3)
                        out_data_q <= clipped;
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_data_q;
    assign code_err = code_err_q;

endmodule
